// File: rtl/pll_clkgen_multi_if.sv
// Bus bundle for pll_clkgen_multi: per-channel divisor/enable in, divided
// clocks, period ticks and lock status out.
// Optional macro PLL_LOCK_LOSS_EN adds lock_lost_clr / lock_lost.
interface pll_clkgen_multi_if #(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = 4
);
  logic [NUM_CH*DIV_W-1:0] div_num;
  logic [NUM_CH-1:0]       clk_out_enable;
  logic [NUM_CH-1:0]       clk_out;
  logic [NUM_CH-1:0]       period_tick;
  logic [NUM_CH-1:0]       locked;
  logic                    all_locked;
`ifdef PLL_LOCK_LOSS_EN
  logic                    lock_lost_clr;
  logic [NUM_CH-1:0]       lock_lost;

  modport master (
    output div_num, clk_out_enable, lock_lost_clr,
    input  clk_out, period_tick, locked, all_locked, lock_lost
  );
  modport slave (
    input  div_num, clk_out_enable, lock_lost_clr,
    output clk_out, period_tick, locked, all_locked, lock_lost
  );
`else
  modport master (
    output div_num, clk_out_enable,
    input  clk_out, period_tick, locked, all_locked
  );
  modport slave (
    input  div_num, clk_out_enable,
    output clk_out, period_tick, locked, all_locked
  );
`endif
endinterface

// File: rtl/pll_clkgen_multi.sv
// Multi-channel registered clock divider. Each channel divides clk_in by its
// own runtime divisor (values below 2 act as 2), emits a registered clock that
// is high for floor(div/2) cycles, a tick in the first cycle of each period,
// and a lock flag once the divisor has been stable for LOCK_PERIODS periods.
// Divisor and enable changes only take effect at period boundaries, so the
// output never produces a runt pulse.
// Optional macro PLL_LOCK_LOSS_EN adds a sticky per-channel lock_lost flag.
module pll_clkgen_multi #(
  parameter int NUM_CH       = 4,
  parameter int DIV_W        = 4,
  parameter int LOCK_PERIODS = 8
) (
  input  logic                    clk_in,
  input  logic                    rst,
  pll_clkgen_multi_if.slave       bus_if
);

  localparam logic [DIV_W-1:0] ONE  = DIV_W'(1);
  localparam logic [DIV_W-1:0] TWO  = DIV_W'(2);
  localparam logic [7:0]       LP   = 8'(LOCK_PERIODS);

  logic [NUM_CH-1:0] locked_d_vec;
  logic              all_locked_q;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [DIV_W-1:0] fld;
      logic [DIV_W-1:0] eff;
      logic             en;
      logic             wrap;
      logic [DIV_W-1:0] cnt_nxt;

      logic [DIV_W-1:0] cnt_q, cnt_d;
      logic [DIV_W-1:0] div_act_q, div_act_d;
      logic [7:0]       lock_cnt_q, lock_cnt_d;
      logic             run_q, run_d;
      logic             clk_q, clk_d;
      logic             tick_q, tick_d;
      logic             locked_q, locked_d;

      assign fld     = bus_if.div_num[gi*DIV_W +: DIV_W];
      assign eff     = (fld < TWO) ? TWO : fld;
      assign en      = bus_if.clk_out_enable[gi];
      assign wrap    = (cnt_q == div_act_q - ONE);
      assign cnt_nxt = wrap ? '0 : cnt_q + ONE;

      // Next-state: start, count, boundary reload/stop and lock qualification
      always_comb begin
        cnt_d      = cnt_q;
        div_act_d  = div_act_q;
        lock_cnt_d = lock_cnt_q;
        run_d      = run_q;
        clk_d      = clk_q;
        tick_d     = 1'b0;
        if (!run_q) begin
          if (en) begin
            run_d  = 1'b1;
            cnt_d  = '0;
            clk_d  = 1'b1;
            tick_d = 1'b1;
          end
        end else begin
          cnt_d  = cnt_nxt;
          tick_d = (cnt_nxt == '0);
          if (wrap) begin
            if (eff != div_act_q) begin
              div_act_d  = eff;
              lock_cnt_d = 8'd0;
            end else if (lock_cnt_q != LP) begin
              lock_cnt_d = lock_cnt_q + 8'd1;
            end
          end
          // Output level is derived from the phase the channel moves into
          clk_d = (cnt_d < (div_act_d >> 1));
          if (wrap && !en) begin
            run_d  = 1'b0;
            cnt_d  = '0;
            clk_d  = 1'b0;
            tick_d = 1'b0;
          end
        end
        // Lock drops as soon as a mismatch or disable is seen, not at the boundary
        locked_d = run_q && en && (lock_cnt_d == LP) && (eff == div_act_q);
      end

      // Channel state registers
      always_ff @(posedge clk_in) begin
        if (rst) begin
          cnt_q      <= '0;
          div_act_q  <= eff;
          lock_cnt_q <= 8'd0;
          run_q      <= 1'b0;
          clk_q      <= 1'b0;
          tick_q     <= 1'b0;
          locked_q   <= 1'b0;
        end else begin
          cnt_q      <= cnt_d;
          div_act_q  <= div_act_d;
          lock_cnt_q <= lock_cnt_d;
          run_q      <= run_d;
          clk_q      <= clk_d;
          tick_q     <= tick_d;
          locked_q   <= locked_d;
        end
      end

      assign locked_d_vec[gi]          = locked_d;
      assign bus_if.clk_out[gi]        = clk_q;
      assign bus_if.period_tick[gi]    = tick_q;
      assign bus_if.locked[gi]         = locked_q;

`ifdef PLL_LOCK_LOSS_EN
      logic lost_q;

      // Sticky loss flag; a new loss wins over a simultaneous clear
      always_ff @(posedge clk_in) begin
        if (rst) begin
          lost_q <= 1'b0;
        end else if (locked_q && !locked_d) begin
          lost_q <= 1'b1;
        end else if (bus_if.lock_lost_clr) begin
          lost_q <= 1'b0;
        end
      end

      assign bus_if.lock_lost[gi] = lost_q;
`endif
    end
  endgenerate

  // Aggregate lock registered from the next-state vector so it aligns with locked
  always_ff @(posedge clk_in) begin
    if (rst) begin
      all_locked_q <= 1'b0;
    end else begin
      all_locked_q <= &locked_d_vec;
    end
  end

  assign bus_if.all_locked = all_locked_q;

endmodule

// File: tb/tb_pll_clkgen_multi.sv
// Directed bench for pll_clkgen_multi (NUM_CH=2, DIV_W=3, LOCK_PERIODS=4).
// Expected outputs are queued as each step is driven and checked after the edge.
// With PLL_LOCK_LOSS_EN defined, the lock_lost checks are compiled in as well.
module tb_pll_clkgen_multi;

  localparam int NUM_CH = 2;
  localparam int DIV_W  = 3;
  localparam int LP     = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pll_clkgen_multi_if #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) bus_if ();

  pll_clkgen_multi #(
    .NUM_CH(NUM_CH),
    .DIV_W(DIV_W),
    .LOCK_PERIODS(LP)
  ) dut (
    .clk_in(clk),
    .rst(rst),
    .bus_if(bus_if)
  );

  typedef struct {
    string      tag;
    logic [1:0] c;
    logic [1:0] t;
    logic [1:0] l;
    logic       a;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic chk(input string tag, input string fld,
                     input logic [1:0] obs, input logic [1:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s %s observed=%b expected=%b", tag, fld, obs, expv);
  endtask

  // One transaction: queue expectation, advance one edge, pop and compare
  task automatic cyc(input string tag, input logic [1:0] c, input logic [1:0] t,
                     input logic [1:0] l, input logic a);
    exp_t e;
    e.tag = tag; e.c = c; e.t = t; e.l = l; e.a = a;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    $display("%s clk_out=%b tick=%b locked=%b all_locked=%b", e.tag,
             bus_if.clk_out, bus_if.period_tick, bus_if.locked, bus_if.all_locked);
    chk(e.tag, "clk_out", bus_if.clk_out, e.c);
    chk(e.tag, "period_tick", bus_if.period_tick, e.t);
    chk(e.tag, "locked", bus_if.locked, e.l);
    chk(e.tag, "all_locked", {1'b0, bus_if.all_locked}, {1'b0, e.a});
  endtask

  task automatic set_div(input int ch, input int d);
    bus_if.div_num[ch*DIV_W +: DIV_W] = 3'(d);
  endtask

  initial begin
    rst = 1'b1;
    bus_if.div_num        = '0;
    bus_if.clk_out_enable = 2'b00;
`ifdef PLL_LOCK_LOSS_EN
    bus_if.lock_lost_clr  = 1'b0;
`endif
    // Scenario 1: ch0 div 4 from reset
    set_div(0, 4);
    set_div(1, 0);
    bus_if.clk_out_enable = 2'b01;
    cyc("reset c0", 2'b00, 2'b00, 2'b00, 1'b0);
    cyc("reset c1", 2'b00, 2'b00, 2'b00, 1'b0);
    rst = 1'b0;
    for (int k = 0; k < 22; k++) begin
      int ph;
      ph = k % 4;
      cyc($sformatf("s1 div4 k=%0d", k), {1'b0, ph < 2}, {1'b0, ph == 0},
          {1'b0, k >= 16}, 1'b0);
    end
    // Scenario 2: divisor 4 -> 2 while cnt=1
    set_div(0, 2);
    cyc("s2 old c2", 2'b00, 2'b00, 2'b00, 1'b0);
    cyc("s2 old c3", 2'b00, 2'b00, 2'b00, 1'b0);
`ifdef PLL_LOCK_LOSS_EN
    chk("s6 lost set", "lock_lost", bus_if.lock_lost, 2'b01);
    bus_if.lock_lost_clr = 1'b1;
`endif
    for (int k = 24; k < 36; k++) begin
      int ph;
      ph = (k - 24) % 2;
      cyc($sformatf("s2 div2 k=%0d", k), {1'b0, ph == 0}, {1'b0, ph == 0},
          {1'b0, k >= 32}, 1'b0);
`ifdef PLL_LOCK_LOSS_EN
      if (k == 24) begin
        chk("s6 lost clr", "lock_lost", bus_if.lock_lost, 2'b00);
        bus_if.lock_lost_clr = 1'b0;
      end
`endif
    end
    // Scenario 3: ch1 div 0 then 1, both behave as div 2
    bus_if.clk_out_enable = 2'b11;
    for (int j = 0; j < 13; j++) begin
      logic hi;
      hi = (j % 2 == 0);
      cyc($sformatf("s3 ch1 j=%0d", j), {hi, hi}, {hi, hi}, {j >= 8, 1'b1}, j >= 8);
      if (j == 3) set_div(1, 1);
    end
    // Scenario 6: reset while both outputs are high
    rst = 1'b1;
    cyc("s6 rst mid-high", 2'b00, 2'b00, 2'b00, 1'b0);
    // Scenario 4: ch0 div 4, enable dropped at cnt=0
    set_div(0, 4);
    bus_if.clk_out_enable = 2'b01;
    cyc("s4 reset", 2'b00, 2'b00, 2'b00, 1'b0);
    rst = 1'b0;
    for (int k = 0; k < 17; k++) begin
      int ph;
      ph = k % 4;
      cyc($sformatf("s4 lockup k=%0d", k), {1'b0, ph < 2}, {1'b0, ph == 0},
          {1'b0, k >= 16}, 1'b0);
    end
    bus_if.clk_out_enable = 2'b00;
    for (int k = 17; k < 23; k++) begin
      cyc($sformatf("s4 drain k=%0d", k), {1'b0, k == 17}, 2'b00, 2'b00, 1'b0);
    end
    bus_if.clk_out_enable = 2'b01;
    cyc("s4 restart", 2'b01, 2'b01, 2'b00, 1'b0);
    // Scenario 5: ch0 div 5, ch1 div 3, aggregate lock
    rst = 1'b1;
    set_div(0, 5);
    set_div(1, 3);
    bus_if.clk_out_enable = 2'b11;
    cyc("s5 reset c0", 2'b00, 2'b00, 2'b00, 1'b0);
    cyc("s5 reset c1", 2'b00, 2'b00, 2'b00, 1'b0);
    rst = 1'b0;
    for (int m = 0; m < 24; m++) begin
      int p0, p1;
      p0 = m % 5;
      p1 = m % 3;
      cyc($sformatf("s5 m=%0d", m), {p1 < 1, p0 < 2}, {p1 == 0, p0 == 0},
          {m >= 12, m >= 20}, m >= 20);
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
